// File: rtl/spaceship_renderer_pkg.sv
// Shared constants and types for the ship sprite pixel pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spaceship_renderer_pkg;

    localparam int SPR_W    = 32;
    localparam int SPR_H    = 32;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int RGB_W    = 8;
    localparam int ANG_W    = 4;
    localparam int CRD_W    = 10;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    // Display enable plus active-low syncs travelling alongside the pixel.
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } tim_t;

    localparam tim_t TIM_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/spaceship_renderer_sprite_hit.sv
// Bounds test of a scan position against a SPR_W x SPR_H sprite box; reusable for other sprites.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module spaceship_renderer_sprite_hit
    import spaceship_renderer_pkg::*;
(
    input  logic [CRD_W-1:0] hcount,
    input  logic [CRD_W-1:0] vcount,
    input  logic [CRD_W-1:0] pos_x,
    input  logic [CRD_W-1:0] pos_y,
    input  logic             de,
    output logic             hit,
    output logic [CRD_W-1:0] dx,
    output logic [CRD_W-1:0] dy
);

    localparam logic [CRD_W:0] SPR_W_L = SPR_W[CRD_W:0];
    localparam logic [CRD_W:0] SPR_H_L = SPR_H[CRD_W:0];

    logic [CRD_W:0] dx_full;
    logic [CRD_W:0] dy_full;

    // Signed offset from the sprite corner; a set sign bit means left of / above the
    // sprite, so a ship near the right edge never wraps onto the start of the line.
    always_comb begin
        dx_full = {1'b0, hcount} - {1'b0, pos_x};
        dy_full = {1'b0, vcount} - {1'b0, pos_y};
        hit     = de
                  && !dx_full[CRD_W] && (dx_full < SPR_W_L)
                  && !dy_full[CRD_W] && (dy_full < SPR_H_L);
        dx      = dx_full[CRD_W-1:0];
        dy      = dy_full[CRD_W-1:0];
    end

endmodule

// File: rtl/spaceship_renderer.sv
// Composites the player ship sprite over the background colour on the VGA pixel stream.
// Latency: 2 pix_en strobes from in_* to out_*; sprite ROM address valid 1 strobe after input.
// Backpressure: none; every register holds while pix_en is low.
module spaceship_renderer
    import spaceship_renderer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic [CRD_W-1:0] in_hcount,
    input  logic [CRD_W-1:0] in_vcount,
    input  logic             in_de,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic [RGB_W-1:0] bg_r,
    input  logic [RGB_W-1:0] bg_g,
    input  logic [RGB_W-1:0] bg_b,
    input  logic [CRD_W-1:0] ship_x,
    input  logic [CRD_W-1:0] ship_y,
    input  logic [ANG_W-1:0] ship_angle,
    output logic [CRD_W-1:0] spr_x,
    output logic [CRD_W-1:0] spr_y,
    output logic [ANG_W-1:0] spr_angle,
    input  logic [RGB_W-1:0] spr_r,
    input  logic [RGB_W-1:0] spr_g,
    input  logic [RGB_W-1:0] spr_b,
    input  logic             spr_a,
    output logic [RGB_W-1:0] out_r,
    output logic [RGB_W-1:0] out_g,
    output logic [RGB_W-1:0] out_b,
    output logic             out_de,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic             frame_tick
);

    logic [CRD_W-1:0] pos_x, pos_y;
    logic [ANG_W-1:0] ang;
    logic             load;
    logic [CRD_W-1:0] cur_x, cur_y;
    logic             hit0;
    logic [CRD_W-1:0] dx0, dy0;

    logic             hit1;
    rgb_t             bg1;
    tim_t             tim1;
    rgb_t             pix2_nxt;
    rgb_t             pix2;
    tim_t             tim2;

    // Load point is the first pixel strobe of vertical blank; the stage-1 lookup
    // on that same strobe already sees the new position.
    assign load  = pix_en && (in_hcount == '0) && (in_vcount == CRD_W'(V_ACTIVE));
    assign cur_x = load ? ship_x : pos_x;
    assign cur_y = load ? ship_y : pos_y;

    spaceship_renderer_sprite_hit u_hit (
        .hcount (in_hcount),
        .vcount (in_vcount),
        .pos_x  (cur_x),
        .pos_y  (cur_y),
        .de     (in_de),
        .hit    (hit0),
        .dx     (dx0),
        .dy     (dy0)
    );

    // Frame-latched ship position and heading so the sprite cannot tear mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x <= '0;
            pos_y <= '0;
            ang   <= '0;
        end else if (load) begin
            pos_x <= ship_x;
            pos_y <= ship_y;
            ang   <= ship_angle;
        end
    end

    // Single-clk pulse marking the shadow register load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_tick <= 1'b0;
        else        frame_tick <= load;
    end

    assign spr_angle = ang;

    // Stage 1: sprite-local address to the ROM, background and timing carried along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1  <= 1'b0;
            spr_x <= '0;
            spr_y <= '0;
            bg1   <= '0;
            tim1  <= TIM_IDLE;
        end else if (pix_en) begin
            hit1  <= hit0;
            spr_x <= hit0 ? dx0 : '0;
            spr_y <= hit0 ? dy0 : '0;
            bg1   <= '{r: bg_r, g: bg_g, b: bg_b};
            tim1  <= '{de: in_de, hsync: in_hsync, vsync: in_vsync};
        end
    end

    // Blanking forces black; an opaque sprite texel covers the background.
    always_comb begin
        pix2_nxt = bg1;
        if (!tim1.de)          pix2_nxt = '0;
        else if (hit1 && spr_a) pix2_nxt = '{r: spr_r, g: spr_g, b: spr_b};
    end

    // Stage 2: composited pixel and timing, aligned for the DAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix2 <= '0;
            tim2 <= TIM_IDLE;
        end else if (pix_en) begin
            pix2 <= pix2_nxt;
            tim2 <= tim1;
        end
    end

    assign out_r     = pix2.r;
    assign out_g     = pix2.g;
    assign out_b     = pix2.b;
    assign out_de    = tim2.de;
    assign out_hsync = tim2.hsync;
    assign out_vsync = tim2.vsync;

endmodule

// File: tb/tb_spaceship_renderer.sv
// Directed bench for spaceship_renderer with a combinational red-sprite ROM model.
// Latency: checks outputs 1 and 2 strobes after each vector.
// Backpressure: exercises pix_en stalls.
module tb_spaceship_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [9:0] in_hcount, in_vcount;
    logic       in_de, in_hsync, in_vsync;
    logic [7:0] bg_r, bg_g, bg_b;
    logic [9:0] ship_x, ship_y;
    logic [3:0] ship_angle;
    logic [9:0] spr_x, spr_y;
    logic [3:0] spr_angle;
    logic [7:0] spr_r, spr_g, spr_b;
    logic       spr_a;
    logic [7:0] out_r, out_g, out_b;
    logic       out_de, out_hsync, out_vsync;
    logic       frame_tick;
    logic       hole_en;
    logic [23:0] out_rgb;

    int nvec = 0;
    int nbad = 0;

    localparam logic [23:0] RED = 24'hFF0000;

    always #5 clk = ~clk;

    // Background pattern derived from the scan position.
    assign bg_r = in_hcount[7:0];
    assign bg_g = in_vcount[7:0];
    assign bg_b = 8'h55;

    // Sprite ROM model: solid red, with an optional transparent texel at (5,5).
    assign spr_r = 8'hFF;
    assign spr_g = 8'h00;
    assign spr_b = 8'h00;
    assign spr_a = !(hole_en && spr_x == 10'd5 && spr_y == 10'd5);

    assign out_rgb = {out_r, out_g, out_b};

    spaceship_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .in_hcount  (in_hcount),
        .in_vcount  (in_vcount),
        .in_de      (in_de),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .bg_r       (bg_r),
        .bg_g       (bg_g),
        .bg_b       (bg_b),
        .ship_x     (ship_x),
        .ship_y     (ship_y),
        .ship_angle (ship_angle),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_angle  (spr_angle),
        .spr_r      (spr_r),
        .spr_g      (spr_g),
        .spr_b      (spr_b),
        .spr_a      (spr_a),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_de     (out_de),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .frame_tick (frame_tick)
    );

    function automatic logic [23:0] bgc(input int h, input int v);
        logic [31:0] hh, vv;
        hh = h;
        vv = v;
        return {hh[7:0], vv[7:0], 8'h55};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel strobe; outputs are sampled 1 time unit after the edge.
    task automatic apply(input int h, input int v, input logic de);
        in_hcount = 10'(h);
        in_vcount = 10'(v);
        in_de     = de;
        @(posedge clk);
        #1;
    endtask

    // Blanked filler vector away from the load point, used to push a pixel out.
    task automatic blank();
        apply(700, 10, 1'b0);
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic [23:0] exp);
        apply(h, v, 1'b1);
        blank();
        chk(tag, {8'h0, out_rgb}, {8'h0, exp});
    endtask

    initial begin
        rst_n      = 1'b0;
        pix_en     = 1'b1;
        in_hcount  = '0;
        in_vcount  = '0;
        in_de      = 1'b0;
        in_hsync   = 1'b1;
        in_vsync   = 1'b1;
        ship_x     = 10'd100;
        ship_y     = 10'd50;
        ship_angle = 4'd3;
        hole_en    = 1'b0;

        // Reset held while the scan runs, including across the load point.
        apply(3, 4, 1'b1);
        apply(0, 480, 1'b0);
        apply(5, 5, 1'b1);
        chk("rst_rgb",   {8'h0, out_rgb}, 32'h0);
        chk("rst_de",    {31'h0, out_de}, 32'h0);
        chk("rst_hsync", {31'h0, out_hsync}, 32'h1);
        chk("rst_vsync", {31'h0, out_vsync}, 32'h1);
        chk("rst_tick",  {31'h0, frame_tick}, 32'h0);
        chk("rst_sprx",  {22'h0, spr_x}, 32'h0);
        chk("rst_ang",   {28'h0, spr_angle}, 32'h0);

        rst_n = 1'b1;

        // Before the first load the ship sits at (0,0).
        apply(3, 4, 1'b1);
        chk("f0_sprx", {22'h0, spr_x}, 32'd3);
        chk("f0_spry", {22'h0, spr_y}, 32'd4);
        chk("f0_ang",  {28'h0, spr_angle}, 32'd0);
        blank();
        chk("f0_rgb", {8'h0, out_rgb}, {8'h0, RED});
        chk("f0_de",  {31'h0, out_de}, 32'h1);

        // Load point with vsync asserted.
        in_vsync = 1'b0;
        apply(0, 480, 1'b0);
        chk("ld1_tick",  {31'h0, frame_tick}, 32'h1);
        chk("ld1_ang",   {28'h0, spr_angle}, 32'd3);
        chk("ld1_vs_s1", {31'h0, out_vsync}, 32'h1);
        in_vsync = 1'b1;
        blank();
        chk("ld1_tick_off", {31'h0, frame_tick}, 32'h0);
        chk("ld1_vs_s2",    {31'h0, out_vsync}, 32'h0);

        // Ship at (100,50): corners drawn, one pixel outside shows background.
        pix("tl_red",   100, 50, RED);
        pix("br_red",   131, 81, RED);
        pix("left_bg",   99, 60, bgc(99, 60));
        pix("right_bg", 132, 60, bgc(132, 60));
        pix("above_bg", 110, 49, bgc(110, 49));
        pix("below_bg", 110, 82, bgc(110, 82));

        // Transparent texel lets the background through.
        hole_en = 1'b1;
        apply(105, 55, 1'b1);
        chk("hole_sprx", {22'h0, spr_x}, 32'd5);
        chk("hole_spry", {22'h0, spr_y}, 32'd5);
        blank();
        chk("hole_rgb", {8'h0, out_rgb}, {8'h0, bgc(105, 55)});
        hole_en = 1'b0;

        // Blanked pixel inside the sprite box is black.
        apply(110, 60, 1'b0);
        blank();
        chk("de0_rgb", {8'h0, out_rgb}, 32'h0);
        chk("de0_de",  {31'h0, out_de}, 32'h0);

        // Mid-frame changes stay hidden until the next load.
        ship_angle = 4'd9;
        ship_x     = 10'd620;
        apply(110, 200 - 150 + 10, 1'b1);
        chk("mid_ang",  {28'h0, spr_angle}, 32'd3);
        chk("mid_sprx", {22'h0, spr_x}, 32'd10);
        blank();
        chk("mid_rgb", {8'h0, out_rgb}, {8'h0, RED});
        apply(100, 200, 1'b1);
        chk("l200_ang", {28'h0, spr_angle}, 32'd3);
        apply(0, 480, 1'b0);
        chk("ld2_tick", {31'h0, frame_tick}, 32'h1);
        chk("ld2_ang",  {28'h0, spr_angle}, 32'd9);
        blank();

        // Ship at x=620: right edge clipped, no wrap to the line start.
        apply(620, 60, 1'b1);
        chk("edge_sprx0", {22'h0, spr_x}, 32'd0);
        chk("edge_spry",  {22'h0, spr_y}, 32'd10);
        blank();
        chk("edge_rgb0", {8'h0, out_rgb}, {8'h0, RED});
        apply(639, 60, 1'b1);
        chk("edge_sprx19", {22'h0, spr_x}, 32'd19);
        blank();
        chk("edge_rgb19", {8'h0, out_rgb}, {8'h0, RED});
        apply(0, 60, 1'b1);
        chk("nowrap_sprx", {22'h0, spr_x}, 32'd0);
        blank();
        chk("nowrap_rgb0", {8'h0, out_rgb}, {8'h0, bgc(0, 60)});
        pix("nowrap_rgb11", 11, 60, bgc(11, 60));
        apply(640, 60, 1'b0);
        blank();
        chk("clip_rgb", {8'h0, out_rgb}, 32'h0);

        // pix_en low for 5 clocks, even across a load-point input: everything holds.
        apply(629, 60, 1'b1);
        apply(630, 60, 1'b1);
        pix_en     = 1'b0;
        ship_angle = 4'd5;
        in_hcount  = 10'd0;
        in_vcount  = 10'd480;
        in_de      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_tick", {31'h0, frame_tick}, 32'h0);
        end
        chk("stall_sprx", {22'h0, spr_x}, 32'd10);
        chk("stall_rgb",  {8'h0, out_rgb}, {8'h0, RED});
        chk("stall_de",   {31'h0, out_de}, 32'h1);
        chk("stall_ang",  {28'h0, spr_angle}, 32'd9);
        pix_en = 1'b1;
        apply(631, 60, 1'b1);
        chk("resume_sprx", {22'h0, spr_x}, 32'd11);
        chk("resume_rgb",  {8'h0, out_rgb}, {8'h0, RED});

        // Asynchronous reset mid-frame, then the ship is back at (0,0).
        rst_n = 1'b0;
        #1;
        chk("arst_rgb",   {8'h0, out_rgb}, 32'h0);
        chk("arst_de",    {31'h0, out_de}, 32'h0);
        chk("arst_hsync", {31'h0, out_hsync}, 32'h1);
        chk("arst_sprx",  {22'h0, spr_x}, 32'h0);
        chk("arst_ang",   {28'h0, spr_angle}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(5, 5, 1'b1);
        chk("post_sprx", {22'h0, spr_x}, 32'd5);
        blank();
        chk("post_rgb", {8'h0, out_rgb}, {8'h0, RED});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
